serial_sub: RTL and testbench

Bit-serial subtractor: computes x − y − bin one bit per clock, LSB first, through a single full-adder cell, trading latency for area against the parallel ripple adders in the arithmetic library. It is the subtraction counterpart of those adders for area-constrained datapaths. A start/busy/done handshake lets a controller FSM launch an operation and pick up the result.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_sub_f_adder.sv | 13 +
 rtl/serial_sub.sv | 121 ++++++++++++
 tb/tb_serial_sub.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// a constant function used to size the bit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_sub_f_adder.sv
// One-bit full adder cell shared by the arithmetic library.
module f_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: x - y - bin evaluated LSB first through one full
// adder cell as x + ~y + ~bin, with a start/busy/done handshake.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] res_sh;
    logic             x_msb;
    logic             y_msb;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             y_inv;
    logic             sum;
    logic             cout;
    logic             load;
    logic             last;

    assign y_inv = ~y_sh[0];
    assign last  = (cnt == LAST_BIT);

    f_adder u_f_adder (
        .a    (x_sh[0]),
        .b    (y_inv),
        .cin  (c),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state and visible results; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            c     <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                c   <= ~bin;
                cnt <= '0;
            end else if (state == ST_SHIFT) begin
                c   <= cout;
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    diff <= {sum, res_sh[WIDTH-1:1]};
                    bout <= ~cout;
                    ovf  <= (x_msb != y_msb) & (sum != x_msb);
                end
            end
        end
    end

    // Operand and partial-result shifters carry no reset; the FSM gates their use.
    always_ff @(posedge clk) begin
        if (load) begin
            x_sh  <= x;
            y_sh  <= y;
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
        end else if (state == ST_SHIFT) begin
            x_sh   <= x_sh >> 1;
            y_sh   <= y_sh >> 1;
            res_sh <= {sum, res_sh[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub at WIDTH=4.
module tb_serial_sub;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int checks;
    int errors;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        x = '0;
        y = '0;
        bin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (diff !== 4'h0) begin errors++; $display("FAIL reset_diff: got %h want 0", diff); end
        checks++;
        if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bout); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sub(input logic [3:0] xv, input logic [3:0] yv, input logic bv,
                            input logic [3:0] exp_diff, input logic exp_bout,
                            input logic exp_ovf, input string name);
        int nb;
        start = 1'b1;
        x = xv;
        y = yv;
        bin = bv;
        @(negedge clk);
        start = 1'b0;
        x = ~xv;
        y = xv ^ yv;
        bin = ~bv;
        nb = 0;
        while (busy === 1'b1 && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        checks++;
        if (nb != 4) begin errors++; $display("FAIL %s_busy_len: got %0d want 4", name, nb); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, done); end
        checks++;
        if (diff !== exp_diff) begin errors++; $display("FAIL %s_diff: got %h want %h", name, diff, exp_diff); end
        checks++;
        if (bout !== exp_bout) begin errors++; $display("FAIL %s_bout: got %b want %b", name, bout, exp_bout); end
        checks++;
        if (ovf !== exp_ovf) begin errors++; $display("FAIL %s_ovf: got %b want %b", name, ovf, exp_ovf); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_after: got done=%b busy=%b want 0 0", name, done, busy);
        end
        checks++;
        if (diff !== exp_diff) begin errors++; $display("FAIL %s_diff_hold: got %h want %h", name, diff, exp_diff); end
    endtask

    task automatic test_ignore_mid();
        int nb;
        start = 1'b1;
        x = 4'd9;
        y = 4'd3;
        bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 20) begin
            if (nb == 2) begin
                start = 1'b1;
                x = 4'd1;
                y = 4'd1;
                bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            nb++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (nb != 4) begin errors++; $display("FAIL ignore_busy_len: got %0d want 4", nb); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", done); end
        checks++;
        if (diff !== 4'h6) begin errors++; $display("FAIL ignore_diff: got %h want 6", diff); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int consec;
        logic prev_done;
        start = 1'b1;
        x = 4'd3;
        y = 4'd5;
        bin = 1'b0;
        ndone = 0;
        consec = 0;
        prev_done = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                x = 4'd9;
                y = 4'd3;
            end
            if (done === 1'b1) ndone++;
            if (done === 1'b1 && prev_done === 1'b1) consec++;
            prev_done = done;
            if (i == 5) begin
                checks++;
                if (done !== 1'b1 || diff !== 4'hE) begin
                    errors++;
                    $display("FAIL b2b_first: got done=%b diff=%h want 1 e", done, diff);
                end
            end
            if (i == 6) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
            end
            if (i == 10) begin
                checks++;
                if (done !== 1'b1 || diff !== 4'h6 || ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_second: got done=%b diff=%h ovf=%b want 1 6 1", done, diff, ovf);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
        checks++;
        if (consec != 0) begin errors++; $display("FAIL b2b_done_consecutive: got %0d want 0", consec); end
        for (int i = 0; i < 20 && (busy !== 1'b0 || done !== 1'b0); i++) begin
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        start = 1'b1;
        x = 4'd8;
        y = 4'd1;
        bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (diff !== 4'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_result: got diff=%h bout=%b ovf=%b want 0 0 0", diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", ndone); end
        test_sub(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0, "after_rst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sub(4'd9,  4'd3, 1'b0, 4'h6, 1'b0, 1'b1, "sub_9_3");
        test_sub(4'd3,  4'd5, 1'b0, 4'hE, 1'b1, 1'b0, "sub_3_5");
        test_sub(4'd0,  4'd0, 1'b1, 4'hF, 1'b1, 1'b0, "sub_0_0_b");
        test_sub(4'd7,  4'd8, 1'b0, 4'hF, 1'b1, 1'b1, "sub_7_8");
        test_sub(4'd8,  4'd1, 1'b0, 4'h7, 1'b0, 1'b1, "sub_8_1");
        test_sub(4'd10, 4'd3, 1'b1, 4'h6, 1'b0, 1'b1, "sub_10_3_b");
        test_sub(4'd5,  4'd5, 1'b0, 4'h0, 1'b0, 1'b0, "sub_5_5");
        test_ignore_mid();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
